// File: rtl/ctl_score_bcd_pkg.sv
// Shared types and constants for the BCD score counter.
// Also holds the elaboration-time check on the point value.
package score_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ADD  = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    // A point value is usable only if it is nonzero and every live nibble is a decimal digit.
    function automatic logic points_valid(input logic [31:0] pts, input int digits);
        logic ok;
        ok = (pts != 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i < digits && pts[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/ctl_score_bcd_if.sv
// Hit/new-game inputs and score/HUD outputs of the score counter.
// The slave modport is the counter's side; the master modport is the game logic's side.
interface ctl_score_bcd_if #(
    parameter int DIGITS = 4
);
    logic                  hit;
    logic                  reset_score;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   hiscore_bcd;
    logic                  busy;
    logic                  saturated;
    logic                  hit_lost;

    modport master (
        output hit, reset_score,
        input  score_bcd, hiscore_bcd, busy, saturated, hit_lost
    );

    modport slave (
        input  hit, reset_score,
        output score_bcd, hiscore_bcd, busy, saturated, hit_lost
    );
endinterface

// File: rtl/ctl_score_bcd_digit_add.sv
// Single-digit BCD adder: a + b + cin with decimal correction.
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);
    logic [4:0] raw;
    logic [4:0] adj;

    // A raw sum above 9 wraps to the next decade by adding 6.
    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        adj  = raw + 5'd6;
        cout = (raw > 5'd9);
        sum  = cout ? adj[3:0] : raw[3:0];
    end
endmodule

// File: rtl/ctl_score_bcd.sv
// Game score counter: queues hit edges, adds POINTS_BCD one digit per cycle,
// saturates at all nines and tracks the best score of the session.
module ctl_score_bcd
    import score_pkg::*;
#(
    parameter int                  DIGITS     = 4,
    parameter logic [4*DIGITS-1:0] POINTS_BCD = 1,
    parameter int                  PEND_W     = 3
) (
    input  logic            clk,
    input  logic            rst,
    ctl_score_bcd_if.slave  bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SW    = 4 * DIGITS;

    if (DIGITS < 2 || DIGITS > 8) begin : g_chk_digits
        $error("ctl_score_bcd: DIGITS must lie in 2..8");
    end
    if (!points_valid(32'(POINTS_BCD), DIGITS)) begin : g_chk_points
        $error("ctl_score_bcd: POINTS_BCD must be nonzero with every nibble <= 9");
    end

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [SW-1:0]      work_q, work_d;
    logic               carry_q, carry_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic [SW-1:0]      score_q, score_d;
    logic [SW-1:0]      hiscore_q, hiscore_d;
    logic               sat_q, sat_d;
    logic               lost_q, lost_d;
    logic               hit_q, hit_d;

    bcd_digit_t dig_a, dig_b, dig_sum;
    logic       dig_cout;
    logic       hit_edge, start_add, last_digit, sat_commit, drop, accept;

    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a = work_q[4*i +: 4];
                dig_b = POINTS_BCD[4*i +: 4];
            end
        end
    end

    bcd_digit_add u_digit_add (
        .a    (dig_a),
        .b    (dig_b),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    // A carry out of the top digit means the true score no longer fits.
    always_comb begin
        hit_edge   = bus.hit & ~hit_q;
        start_add  = (state_q == ST_IDLE) && (pend_q != '0) && !sat_q;
        last_digit = (state_q == ST_ADD) && (idx_q == IDX_W'(DIGITS - 1));
        sat_commit = last_digit && dig_cout;
        drop       = hit_edge && ((&pend_q) || sat_q || sat_commit);
        accept     = hit_edge && !drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            work_q    <= '0;
            carry_q   <= 1'b0;
            pend_q    <= '0;
            score_q   <= '0;
            hiscore_q <= '0;
            sat_q     <= 1'b0;
            lost_q    <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            work_q    <= work_d;
            carry_q   <= carry_d;
            pend_q    <= pend_d;
            score_q   <= score_d;
            hiscore_q <= hiscore_d;
            sat_q     <= sat_d;
            lost_q    <= lost_d;
            hit_q     <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_add)  state_d = ST_ADD;
            ST_ADD:  if (last_digit) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.reset_score) begin
            state_d = ST_IDLE;
        end
    end

    // A new game abandons any in-flight addition; the partial work is simply never committed.
    always_comb begin
        idx_d     = idx_q;
        work_d    = work_q;
        carry_d   = carry_q;
        pend_d    = pend_q;
        score_d   = score_q;
        hiscore_d = hiscore_q;
        sat_d     = sat_q;
        lost_d    = 1'b0;
        hit_d     = bus.hit;

        if (bus.reset_score) begin
            score_d = '0;
            pend_d  = '0;
            sat_d   = 1'b0;
            idx_d   = '0;
            carry_d = 1'b0;
            if (score_q > hiscore_q) begin
                hiscore_d = score_q;
            end
        end else begin
            lost_d = drop;
            pend_d = pend_q + PEND_W'(accept) - PEND_W'(start_add);
            if (start_add) begin
                idx_d   = '0;
                work_d  = score_q;
                carry_d = 1'b0;
            end else if (state_q == ST_ADD) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        work_d[4*i +: 4] = dig_sum;
                    end
                end
                carry_d = dig_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_digit) begin
                    idx_d   = '0;
                    carry_d = 1'b0;
                    if (dig_cout) begin
                        score_d = {DIGITS{BCD_NINE}};
                        sat_d   = 1'b1;
                        pend_d  = '0;
                    end else begin
                        score_d = work_d;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.score_bcd   = score_q;
        bus.hiscore_bcd = hiscore_q;
        bus.busy        = (state_q == ST_ADD);
        bus.saturated   = sat_q;
        bus.hit_lost    = lost_q;
    end

endmodule

// File: tb/tb_ctl_score_bcd.sv
// Drives three score counters (4 digits/+1, 4 digits/+5, 2 digits/+5) from shared inputs
// and compares every output each cycle with a decimal-arithmetic reference model.
module tb_ctl_score_bcd;

    localparam int MAXPEND = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic reset_score = 1'b0;
    logic hit = 1'b0;

    always #5 clk = ~clk;

    ctl_score_bcd_if #(.DIGITS(4)) if0 ();
    ctl_score_bcd_if #(.DIGITS(4)) if1 ();
    ctl_score_bcd_if #(.DIGITS(2)) if2 ();

    assign if0.hit = hit;
    assign if1.hit = hit;
    assign if2.hit = hit;
    assign if0.reset_score = reset_score;
    assign if1.reset_score = reset_score;
    assign if2.reset_score = reset_score;

    ctl_score_bcd #(.DIGITS(4), .POINTS_BCD(16'h0001), .PEND_W(3)) u_dut0 (
        .clk (clk), .rst (rst), .bus (if0)
    );
    ctl_score_bcd #(.DIGITS(4), .POINTS_BCD(16'h0005), .PEND_W(3)) u_dut1 (
        .clk (clk), .rst (rst), .bus (if1)
    );
    ctl_score_bcd #(.DIGITS(2), .POINTS_BCD(8'h05), .PEND_W(3)) u_dut2 (
        .clk (clk), .rst (rst), .bus (if2)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state per instance: scores as plain integers, ADD as a countdown.
    int m_score [3];
    int m_hi    [3];
    int m_pend  [3];
    int m_cnt   [3];
    bit m_sat   [3];
    bit m_lost  [3];
    bit m_hit_prev;
    int digits_of [3] = '{4, 4, 2};
    int points_of [3] = '{1, 5, 5};

    typedef struct {
        bit          rst;
        bit          rs;
        bit          hit;
        logic [15:0] score;
        bit          busy;
        bit          lost;
    } vec_t;

    vec_t tbl [15];

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_step(input bit r, input bit rs, input bit h);
        bit edge_seen;
        edge_seen = h && !m_hit_prev;
        for (int u = 0; u < 3; u++) begin
            bit start;
            bit sat_commit;
            int sum;
            int top;
            top = 10 ** digits_of[u] - 1;
            sum = m_score[u] + points_of[u];
            if (r) begin
                m_score[u] = 0; m_hi[u] = 0; m_pend[u] = 0;
                m_cnt[u] = 0; m_sat[u] = 0; m_lost[u] = 0;
            end else if (rs) begin
                if (m_score[u] > m_hi[u]) m_hi[u] = m_score[u];
                m_score[u] = 0; m_pend[u] = 0; m_cnt[u] = 0;
                m_sat[u] = 0; m_lost[u] = 0;
            end else begin
                start      = (m_cnt[u] == 0) && (m_pend[u] > 0) && !m_sat[u];
                sat_commit = (m_cnt[u] == 1) && (sum > top);
                m_lost[u]  = edge_seen && (m_pend[u] == MAXPEND || m_sat[u] || sat_commit);
                if (edge_seen && !m_lost[u]) m_pend[u]++;
                if (start) begin
                    m_pend[u]--;
                    m_cnt[u] = digits_of[u];
                end else if (m_cnt[u] > 0) begin
                    if (m_cnt[u] == 1) begin
                        if (sat_commit) begin
                            m_score[u] = top;
                            m_sat[u]   = 1;
                            m_pend[u]  = 0;
                        end else begin
                            m_score[u] = sum;
                        end
                    end
                    m_cnt[u]--;
                end
            end
        end
        m_hit_prev = r ? 1'b0 : h;
    endtask

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic checkOutput();
        check_field("u0_score",   32'(if0.score_bcd),   to_bcd(m_score[0]));
        check_field("u0_hiscore", 32'(if0.hiscore_bcd), to_bcd(m_hi[0]));
        check_field("u0_busy",    32'(if0.busy),        32'(m_cnt[0] > 0));
        check_field("u0_sat",     32'(if0.saturated),   32'(m_sat[0]));
        check_field("u0_lost",    32'(if0.hit_lost),    32'(m_lost[0]));
        check_field("u1_score",   32'(if1.score_bcd),   to_bcd(m_score[1]));
        check_field("u1_hiscore", 32'(if1.hiscore_bcd), to_bcd(m_hi[1]));
        check_field("u1_busy",    32'(if1.busy),        32'(m_cnt[1] > 0));
        check_field("u1_sat",     32'(if1.saturated),   32'(m_sat[1]));
        check_field("u1_lost",    32'(if1.hit_lost),    32'(m_lost[1]));
        check_field("u2_score",   32'(if2.score_bcd),   to_bcd(m_score[2]));
        check_field("u2_hiscore", 32'(if2.hiscore_bcd), to_bcd(m_hi[2]));
        check_field("u2_busy",    32'(if2.busy),        32'(m_cnt[2] > 0));
        check_field("u2_sat",     32'(if2.saturated),   32'(m_sat[2]));
        check_field("u2_lost",    32'(if2.hit_lost),    32'(m_lost[2]));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic applyStimulus(input bit r, input bit rs, input bit h);
        rst = r;
        reset_score = rs;
        hit = h;
        @(posedge clk);
        model_step(r, rs, h);
        #1;
        checkOutput();
    endtask

    task automatic one_hit();
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    int lost_seen;

    initial begin
        tbl[0]  = '{1, 0, 0, 16'h0000, 0, 0};
        tbl[1]  = '{1, 0, 0, 16'h0000, 0, 0};
        tbl[2]  = '{1, 0, 0, 16'h0000, 0, 0};
        tbl[3]  = '{0, 0, 1, 16'h0000, 0, 0};
        tbl[4]  = '{0, 0, 0, 16'h0000, 1, 0};
        tbl[5]  = '{0, 0, 0, 16'h0000, 1, 0};
        tbl[6]  = '{0, 0, 0, 16'h0000, 1, 0};
        tbl[7]  = '{0, 0, 0, 16'h0000, 1, 0};
        tbl[8]  = '{0, 0, 0, 16'h0001, 0, 0};
        tbl[9]  = '{0, 0, 1, 16'h0001, 0, 0};
        tbl[10] = '{0, 0, 0, 16'h0001, 1, 0};
        tbl[11] = '{0, 0, 0, 16'h0001, 1, 0};
        tbl[12] = '{0, 0, 0, 16'h0001, 1, 0};
        tbl[13] = '{0, 0, 0, 16'h0001, 1, 0};
        tbl[14] = '{0, 0, 0, 16'h0002, 0, 0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].rs, tbl[i].hit);
            check_field("tbl_score", 32'(if0.score_bcd), 32'(tbl[i].score));
            check_field("tbl_busy",  32'(if0.busy),      32'(tbl[i].busy));
            check_field("tbl_lost",  32'(if0.hit_lost),  32'(tbl[i].lost));
        end

        one_hit();
        check_field("three_hits", 32'(if0.score_bcd), 32'h0003);

        $display("[TB] carry chain and saturation");
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (19) one_hit();
        check_field("u1_at_95", 32'(if1.score_bcd), 32'h0095);
        check_field("u2_at_95", 32'(if2.score_bcd), 32'h0095);
        one_hit();
        check_field("u1_95_to_100", 32'(if1.score_bcd), 32'h0100);
        check_field("u2_clamp_99",  32'(if2.score_bcd), 32'h0099);
        check_field("u2_sat_flag",  32'(if2.saturated), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        check_field("u2_lost_pulse", 32'(if2.hit_lost), 32'h1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
        check_field("u2_still_99", 32'(if2.score_bcd), 32'h0099);
        check_field("u0_at_21",    32'(if0.score_bcd), 32'h0021);

        $display("[TB] new game during addition");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        check_field("ng_score",   32'(if0.score_bcd),   32'h0000);
        check_field("ng_busy",    32'(if0.busy),        32'h0);
        check_field("ng_hiscore", 32'(if0.hiscore_bcd), 32'h0021);
        repeat (10) one_hit();
        check_field("ng_score_10", 32'(if0.score_bcd), 32'h0010);
        applyStimulus(1'b0, 1'b1, 1'b0);
        check_field("ng_hiscore_kept", 32'(if0.hiscore_bcd), 32'h0021);

        $display("[TB] edge together with new game");
        applyStimulus(1'b0, 1'b1, 1'b1);
        check_field("sim_score", 32'(if0.score_bcd), 32'h0000);
        check_field("sim_lost",  32'(if0.hit_lost),  32'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        check_field("sim_no_add", 32'(if0.busy), 32'h0);

        $display("[TB] queue overflow");
        lost_seen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 2) == 0);
            if (if0.hit_lost) lost_seen++;
        end
        check_field("queue_overflow_seen", 32'(lost_seen > 0), 32'h1);
        repeat (60) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] 0999 plus one");
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (999) one_hit();
        check_field("u0_at_999", 32'(if0.score_bcd), 32'h0999);
        one_hit();
        check_field("u0_999_to_1000", 32'(if0.score_bcd), 32'h1000);

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 63) == 0,
                          1'($urandom_range(0, 1)));
        end

        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        check_field("rst_beats_new_game", 32'(if0.hiscore_bcd), 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
